// File: rtl/cpu_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cpu_bus_arbiter
// Purpose  : Shares one external memory port between the CPU instruction bus
//            and the CPU data bus. Request pulses are captured in per-port
//            pending slots, one memory transaction is outstanding at a time,
//            and read data / acknowledge are routed back to the owner.
// Options  : CPU_BUS_ARB_ROUND_ROBIN_EN - when defined, contention is resolved
//            in favour of the port not granted most recently; otherwise the
//            data port always wins.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_bus_arbiter (
    input  logic        clock,
    input  logic        reset,
    // instruction bus
    input  logic        cpui_request,
    input  logic [31:0] cpui_addr,
    output logic [31:0] cpui_rdata,
    output logic        cpui_ack,
    // data bus
    input  logic        cpud_request,
    input  logic        cpud_write,
    input  logic [31:0] cpud_addr,
    input  logic [31:0] cpud_wdata,
    input  logic [3:0]  cpud_wmask,
    output logic [31:0] cpud_rdata,
    output logic        cpud_ack,
    // memory port
    output logic        mem_request,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    // status
    output logic        arb_error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t      state, state_nx;

    logic        pend_i, pend_i_nx;
    logic [31:0] pend_i_addr, pend_i_addr_nx;

    logic        pend_d, pend_d_nx;
    logic        pend_d_write, pend_d_write_nx;
    logic [31:0] pend_d_addr, pend_d_addr_nx;
    logic [31:0] pend_d_wdata, pend_d_wdata_nx;
    logic [3:0]  pend_d_wmask, pend_d_wmask_nx;

    logic        mem_request_nx;
    logic        mem_write_nx;
    logic [31:0] mem_addr_nx;
    logic [31:0] mem_wdata_nx;
    logic [3:0]  mem_wmask_nx;
    logic        arb_error_nx;

    // Data port wins a tie when this is high.
    logic        prefer_d;

`ifdef CPU_BUS_ARB_ROUND_ROBIN_EN
    // 1 = data port was granted last, 0 = instruction port.
    logic        last_grant, last_grant_nx;
    assign prefer_d = ~last_grant;
`else
    assign prefer_d = 1'b1;
`endif

    // Completion is forwarded combinationally to whichever port owns the bus.
    assign cpui_ack   = (state == BUSY_I) && mem_ack;
    assign cpud_ack   = (state == BUSY_D) && mem_ack;
    assign cpui_rdata = mem_rdata;
    assign cpud_rdata = mem_rdata;

    // State, pending slots and registered memory-port outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            pend_i       <= 1'b0;
            pend_i_addr  <= 32'd0;
            pend_d       <= 1'b0;
            pend_d_write <= 1'b0;
            pend_d_addr  <= 32'd0;
            pend_d_wdata <= 32'd0;
            pend_d_wmask <= 4'd0;
            mem_request  <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            mem_wmask    <= 4'd0;
            arb_error    <= 1'b0;
`ifdef CPU_BUS_ARB_ROUND_ROBIN_EN
            last_grant   <= 1'b0;
`endif
        end else begin
            state        <= state_nx;
            pend_i       <= pend_i_nx;
            pend_i_addr  <= pend_i_addr_nx;
            pend_d       <= pend_d_nx;
            pend_d_write <= pend_d_write_nx;
            pend_d_addr  <= pend_d_addr_nx;
            pend_d_wdata <= pend_d_wdata_nx;
            pend_d_wmask <= pend_d_wmask_nx;
            mem_request  <= mem_request_nx;
            mem_write    <= mem_write_nx;
            mem_addr     <= mem_addr_nx;
            mem_wdata    <= mem_wdata_nx;
            mem_wmask    <= mem_wmask_nx;
            arb_error    <= arb_error_nx;
`ifdef CPU_BUS_ARB_ROUND_ROBIN_EN
            last_grant   <= last_grant_nx;
`endif
        end
    end

    // Request capture, protocol checking and grant selection.
    always_comb begin
        state_nx        = state;
        pend_i_nx       = pend_i;
        pend_i_addr_nx  = pend_i_addr;
        pend_d_nx       = pend_d;
        pend_d_write_nx = pend_d_write;
        pend_d_addr_nx  = pend_d_addr;
        pend_d_wdata_nx = pend_d_wdata;
        pend_d_wmask_nx = pend_d_wmask;
        mem_request_nx  = 1'b0;
        mem_write_nx    = mem_write;
        mem_addr_nx     = mem_addr;
        mem_wdata_nx    = mem_wdata;
        mem_wmask_nx    = mem_wmask;
        arb_error_nx    = arb_error;
`ifdef CPU_BUS_ARB_ROUND_ROBIN_EN
        last_grant_nx   = last_grant;
`endif

        // A pulse is legal only if its slot is empty and the port does not
        // own a transaction that is still in flight this cycle.
        if (cpui_request) begin
            if (pend_i || ((state == BUSY_I) && !mem_ack)) begin
                arb_error_nx = 1'b1;
            end else begin
                pend_i_nx      = 1'b1;
                pend_i_addr_nx = cpui_addr;
            end
        end
        if (cpud_request) begin
            if (pend_d || ((state == BUSY_D) && !mem_ack)) begin
                arb_error_nx = 1'b1;
            end else begin
                pend_d_nx       = 1'b1;
                pend_d_write_nx = cpud_write;
                pend_d_addr_nx  = cpud_addr;
                pend_d_wdata_nx = cpud_wdata;
                pend_d_wmask_nx = cpud_wmask;
            end
        end

        // The bus is free when idle or when the current transaction ends now.
        if ((state == IDLE) || mem_ack) begin
            state_nx = IDLE;
            if (pend_d_nx && (!pend_i_nx || prefer_d)) begin
                state_nx       = BUSY_D;
                mem_request_nx = 1'b1;
                mem_write_nx   = pend_d_write_nx;
                mem_addr_nx    = pend_d_addr_nx;
                mem_wdata_nx   = pend_d_wdata_nx;
                mem_wmask_nx   = pend_d_wmask_nx;
                pend_d_nx      = 1'b0;
`ifdef CPU_BUS_ARB_ROUND_ROBIN_EN
                last_grant_nx  = 1'b1;
`endif
            end else if (pend_i_nx) begin
                state_nx       = BUSY_I;
                mem_request_nx = 1'b1;
                mem_write_nx   = 1'b0;
                mem_addr_nx    = pend_i_addr_nx;
                mem_wdata_nx   = 32'd0;
                mem_wmask_nx   = 4'd0;
                pend_i_nx      = 1'b0;
`ifdef CPU_BUS_ARB_ROUND_ROBIN_EN
                last_grant_nx  = 1'b0;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_bus_arbiter
// Purpose  : Directed self-checking bench for cpu_bus_arbiter with a
//            transaction-level reference model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_arbiter;

`ifdef CPU_BUS_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        cpui_request;
    logic [31:0] cpui_addr;
    logic [31:0] cpui_rdata;
    logic        cpui_ack;
    logic        cpud_request;
    logic        cpud_write;
    logic [31:0] cpud_addr;
    logic [31:0] cpud_wdata;
    logic [3:0]  cpud_wmask;
    logic [31:0] cpud_rdata;
    logic        cpud_ack;
    logic        mem_request;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        arb_error;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    cpu_bus_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .cpui_request (cpui_request),
        .cpui_addr    (cpui_addr),
        .cpui_rdata   (cpui_rdata),
        .cpui_ack     (cpui_ack),
        .cpud_request (cpud_request),
        .cpud_write   (cpud_write),
        .cpud_addr    (cpud_addr),
        .cpud_wdata   (cpud_wdata),
        .cpud_wmask   (cpud_wmask),
        .cpud_rdata   (cpud_rdata),
        .cpud_ack     (cpud_ack),
        .mem_request  (mem_request),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .arb_error    (arb_error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: port 0 = instruction, port 1 = data. Each port has
    // a waiting request; 'owner' is the port whose transaction is on the
    // memory bus (-1 = none).
    // ------------------------------------------------------------------
    bit          m_wait [2];
    bit          m_wr   [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wd   [2];
    logic [3:0]  m_wm   [2];
    int          owner;
    int          m_last;
    bit          e_req, e_wr, e_err;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_wm;
    bit          started = 1'b0;

    // Advance the model by one clock using the inputs the DUT samples.
    always @(posedge clock) begin
        bit rq [2];
        bit done;
        int win;
        if (reset) begin
            for (int p = 0; p < 2; p++) m_wait[p] = 1'b0;
            owner = -1; m_last = 0;
            e_req = 0; e_wr = 0; e_addr = 0; e_wd = 0; e_wm = 0; e_err = 0;
            started = 1'b1;
        end else if (started) begin
            rq[0] = cpui_request;
            rq[1] = cpud_request;
            done  = (owner >= 0) && mem_ack;
            for (int p = 0; p < 2; p++) begin
                if (rq[p]) begin
                    if (m_wait[p] || (owner == p && !done)) begin
                        e_err = 1'b1;
                    end else begin
                        m_wait[p] = 1'b1;
                        if (p == 0) begin
                            m_wr[p] = 0; m_addr[p] = cpui_addr; m_wd[p] = 0; m_wm[p] = 0;
                        end else begin
                            m_wr[p] = cpud_write; m_addr[p] = cpud_addr;
                            m_wd[p] = cpud_wdata; m_wm[p] = cpud_wmask;
                        end
                    end
                end
            end
            e_req = 1'b0;
            if (owner < 0 || done) begin
                win = -1;
                if (m_wait[0] && m_wait[1]) win = RR ? ((m_last == 1) ? 0 : 1) : 1;
                else if (m_wait[0])         win = 0;
                else if (m_wait[1])         win = 1;
                owner = win;
                if (win >= 0) begin
                    e_req = 1'b1;
                    e_wr = m_wr[win]; e_addr = m_addr[win];
                    e_wd = m_wd[win]; e_wm = m_wm[win];
                    m_wait[win] = 1'b0;
                    m_last = win;
                end
            end
        end
    end

    // Compare every DUT output against the model mid-cycle.
    always @(negedge clock) begin
        bit ei, ed;
        if (started) begin
            ei = (owner == 0) && mem_ack;
            ed = (owner == 1) && mem_ack;
            chk("mem_request", {31'd0, mem_request}, {31'd0, e_req});
            chk("mem_write",   {31'd0, mem_write},   {31'd0, e_wr});
            chk("mem_addr",    mem_addr,             e_addr);
            chk("mem_wdata",   mem_wdata,            e_wd);
            chk("mem_wmask",   {28'd0, mem_wmask},   {28'd0, e_wm});
            chk("cpui_ack",    {31'd0, cpui_ack},    {31'd0, ei});
            chk("cpud_ack",    {31'd0, cpud_ack},    {31'd0, ed});
            chk("arb_error",   {31'd0, arb_error},   {31'd0, e_err});
            if (ei) chk("cpui_rdata", cpui_rdata, mem_rdata);
            if (ed) chk("cpud_rdata", cpud_rdata, mem_rdata);
        end
    end

    task automatic go();
        @(posedge clock);
        #1;
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin
        reset = 1; cpui_request = 0; cpui_addr = 0;
        cpud_request = 0; cpud_write = 0; cpud_addr = 0; cpud_wdata = 0; cpud_wmask = 0;
        mem_rdata = 0; mem_ack = 0;
        go(); go();
        reset = 0;
        #2;
        chk("rst mem_request", {31'd0, mem_request}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst arb_error", {31'd0, arb_error}, 32'd0);

        // single fetch
        go();
        cpui_request = 1; cpui_addr = 32'hFFFF_0000;
        go(); cpui_request = 0; #2;
        chk("fetch mem_request", {31'd0, mem_request}, 32'd1);
        chk("fetch mem_addr", mem_addr, 32'hFFFF_0000);
        chk("fetch mem_write", {31'd0, mem_write}, 32'd0);
        go(); #2;
        chk("fetch req one cycle", {31'd0, mem_request}, 32'd0);
        go(); mem_ack = 1; mem_rdata = 32'h1234_5678; #2;
        chk("fetch cpui_ack", {31'd0, cpui_ack}, 32'd1);
        chk("fetch cpui_rdata", cpui_rdata, 32'h1234_5678);
        chk("fetch cpud_ack", {31'd0, cpud_ack}, 32'd0);
        go(); mem_ack = 0;

        // simultaneous requests: data wins (also under round-robin, last was instr)
        cpui_request = 1; cpui_addr = 32'h100;
        cpud_request = 1; cpud_write = 0; cpud_addr = 32'h2000;
        go(); cpui_request = 0; cpud_request = 0; #2;
        chk("sim first addr", mem_addr, 32'h2000);
        go(); mem_ack = 1; mem_rdata = 32'hAAAA_0001; #2;
        chk("sim cpud_ack", {31'd0, cpud_ack}, 32'd1);
        chk("sim cpud_rdata", cpud_rdata, 32'hAAAA_0001);
        chk("sim cpui_ack", {31'd0, cpui_ack}, 32'd0);
        go(); mem_ack = 0; #2;
        chk("sim second req", {31'd0, mem_request}, 32'd1);
        chk("sim second addr", mem_addr, 32'h100);
        go(); mem_ack = 1; mem_rdata = 32'hBBBB_0002; #2;
        chk("sim cpui_ack", {31'd0, cpui_ack}, 32'd1);
        go(); mem_ack = 0;

        // write with fields held until mem_ack
        cpud_request = 1; cpud_write = 1; cpud_addr = 32'h3000;
        cpud_wdata = 32'hDEAD_BEEF; cpud_wmask = 4'h3;
        go(); cpud_request = 0; cpud_write = 0; cpud_addr = 0; cpud_wdata = 0; cpud_wmask = 0; #2;
        chk("wr mem_write", {31'd0, mem_write}, 32'd1);
        chk("wr mem_addr", mem_addr, 32'h3000);
        chk("wr mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("wr mem_wmask", {28'd0, mem_wmask}, 32'h3);
        go(); go(); #2;
        chk("wr held wdata", mem_wdata, 32'hDEAD_BEEF);
        mem_ack = 1; #1;
        chk("wr cpud_ack", {31'd0, cpud_ack}, 32'd1);
        go(); mem_ack = 0;

        // second contention: last grant was data
        cpui_request = 1; cpui_addr = 32'h400;
        cpud_request = 1; cpud_write = 0; cpud_addr = 32'h5000;
        go(); cpui_request = 0; cpud_request = 0; #2;
        chk("rr first addr", mem_addr, RR ? 32'h400 : 32'h5000);
        go(); mem_ack = 1; mem_rdata = 32'hC0C0_C0C0;
        go(); mem_ack = 0; #2;
        chk("rr second addr", mem_addr, RR ? 32'h5000 : 32'h400);
        go(); mem_ack = 1;
        go(); mem_ack = 0;

        // back-to-back: instruction pending while data busy
        cpud_request = 1; cpud_addr = 32'h6000;
        go(); cpud_request = 0;
        cpui_request = 1; cpui_addr = 32'h700;
        go(); cpui_request = 0;
        go(); mem_ack = 1; mem_rdata = 32'hD0D0_D0D0; #2;
        chk("b2b cpud_ack", {31'd0, cpud_ack}, 32'd1);
        chk("b2b cpui_ack", {31'd0, cpui_ack}, 32'd0);
        go(); mem_ack = 0; #2;
        chk("b2b next req", {31'd0, mem_request}, 32'd1);
        chk("b2b next addr", mem_addr, 32'h700);
        go(); mem_ack = 1; #2;
        chk("b2b cpui_ack", {31'd0, cpui_ack}, 32'd1);
        go(); mem_ack = 0;

        // protocol violation: second fetch before ack
        cpui_request = 1; cpui_addr = 32'h800;
        go(); cpui_addr = 32'h900;
        go(); cpui_request = 0; #2;
        chk("viol arb_error", {31'd0, arb_error}, 32'd1);
        chk("viol addr kept", mem_addr, 32'h800);
        go(); mem_ack = 1; mem_rdata = 32'hE0E0_E0E0; #2;
        chk("viol cpui_ack", {31'd0, cpui_ack}, 32'd1);
        chk("viol cpui_rdata", cpui_rdata, 32'hE0E0_E0E0);
        go(); mem_ack = 0; #2;
        chk("viol sticky", {31'd0, arb_error}, 32'd1);
        chk("viol no reissue", {31'd0, mem_request}, 32'd0);

        // reset while instruction transaction outstanding
        cpui_request = 1; cpui_addr = 32'hA00;
        go(); cpui_request = 0;
        go(); reset = 1;
        go(); reset = 0;
        go(); mem_ack = 1; mem_rdata = 32'hF0F0_F0F0; #2;
        chk("rst stale cpui_ack", {31'd0, cpui_ack}, 32'd0);
        chk("rst arb_error", {31'd0, arb_error}, 32'd0);
        chk("rst no request", {31'd0, mem_request}, 32'd0);
        go(); mem_ack = 0;
        cpui_request = 1; cpui_addr = 32'hB00;
        go(); cpui_request = 0; #2;
        chk("post-rst req", {31'd0, mem_request}, 32'd1);
        chk("post-rst addr", mem_addr, 32'hB00);
        go(); mem_ack = 1; mem_rdata = 32'h0BAD_F00D; #2;
        chk("post-rst cpui_ack", {31'd0, cpui_ack}, 32'd1);
        go(); mem_ack = 0;
        go(); go();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
